// File: rtl/tdc_calib_pkg.sv
// tdc_calib_pkg: state encoding and rd_data field positions shared by the capture buffer
package tdc_calib_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 16;
  localparam int CODE_LSB = 0;
endpackage

// File: rtl/tdc_calib_capture_buf_if.sv
// tdc_calib_capture_buf_if: first-word-fall-through read port of the capture buffer
//   rd_data_o  : head entry {tag, zero pad, code}, 0 when empty
//   rd_valid_o : buffer not empty
//   pop_i      : consumer advances the head
interface tdc_calib_capture_buf_if;
  logic [31:0] rd_data_o;
  logic rd_valid_o;
  logic pop_i;
  modport master (output rd_data_o, rd_valid_o, input pop_i);
  modport slave (input rd_data_o, rd_valid_o, output pop_i);
endinterface

// File: rtl/tdc_calib_fwft_fifo.sv
// tdc_calib_fwft_fifo: first-word-fall-through FIFO with wrap-bit pointers
//   clk, rst_n        : clock, asynchronous active-low reset (pointers only)
//   flush             : empty the FIFO on this edge
//   wr, wr_data       : push request; taken when not full or when a pop frees a slot
//   pop               : remove head; ignored when empty
//   rd_data, rd_valid : head entry (0 when empty), not-empty flag
//   full, level       : occupancy status
module tdc_calib_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign level = wp - rp;
  assign rd_valid = wp != rp;
  // Same slot index on different laps means the write pointer is a full lap ahead.
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = pop && rd_valid;
  assign do_wr = wr && (!full || do_rd);
  assign rd_data = rd_valid ? mem[rp[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, do_wr};
      rp <= rp + {{AW{1'b0}}, do_rd};
    end
endmodule

// File: rtl/tdc_calib_capture_buf.sv
// tdc_calib_capture_buf: armed, triggered capture of TDC fine codes into a tagged FWFT buffer
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   tdc_code_i, tdc_valid_i       : decoded fine code stream
//   trig_i                        : trigger level, rising edge starts capture
//   arm_i, abort_i, target_i      : control pulses and sample target (latched on arm)
//   rd                            : read port (rd_data_o, rd_valid_o, pop_i)
//   level_o, count_o, state_o     : occupancy, samples since arm, IDLE/ARMED/CAPTURE/DONE
//   overflow_o                    : sticky, a sample was dropped on a full buffer
// Optional macro TDC_CALIB_CAPTURE_TIMESTAMP_EN: tag holds a 16-bit cycle stamp instead of the sample index.
module tdc_calib_capture_buf
  import tdc_calib_pkg::*;
#(
  parameter int CODE_W = 10,
  parameter int DEPTH = 16
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic [CODE_W-1:0]      tdc_code_i,
  input  logic                   tdc_valid_i,
  input  logic                   trig_i,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [15:0]            target_i,
  tdc_calib_capture_buf_if.master rd,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [15:0]            count_o,
  output logic [1:0]             state_o,
  output logic                   overflow_o
);
  state_t state_q, state_d;
  logic trig_q, full, arm_ok, trig_rise, accept;
  logic [15:0] target_q, tag;
  logic [31:0] wr_word;
  assign trig_rise = trig_i && !trig_q;
  // Abort beats arm, and arm is only honoured while not capturing.
  assign arm_ok = arm_i && !abort_i && (state_q == IDLE || state_q == DONE);
  assign accept = state_q == CAPTURE && tdc_valid_i && !abort_i;
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arm_i ? ARMED : IDLE;
      ARMED:   state_d = !trig_rise ? ARMED : target_q == '0 ? DONE : CAPTURE;
      CAPTURE: state_d = accept && count_o + 16'd1 == target_q ? DONE : CAPTURE;
      DONE:    state_d = arm_i ? ARMED : DONE;
    endcase
    if (abort_i) state_d = IDLE;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      target_q <= '0;
      count_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q <= trig_i;
      if (arm_ok) begin
        target_q <= target_i;
        count_o <= '0;
        overflow_o <= 1'b0;
      end else if (accept) begin
        count_o <= count_o + 16'd1;
        // Full implies non-empty, so a pop here always frees a slot for this sample.
        if (full && !rd.pop_i) overflow_o <= 1'b1;
      end
    end
`ifdef TDC_CALIB_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) ts_q <= '0;
    else ts_q <= arm_ok ? '0 : ts_q + 16'd1;
  assign tag = ts_q;
`else
  assign tag = count_o;
`endif
  always_comb begin
    wr_word = '0;
    wr_word[TAG_MSB:TAG_LSB] = tag;
    wr_word[CODE_LSB +: CODE_W] = tdc_code_i;
  end
  tdc_calib_fwft_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .flush    (arm_ok),
    .wr       (accept),
    .wr_data  (wr_word),
    .pop      (rd.pop_i),
    .rd_data  (rd.rd_data_o),
    .rd_valid (rd.rd_valid_o),
    .full     (full),
    .level    (level_o)
  );
endmodule
